iter_shift_unit: RTL and testbench

- Multi-cycle shifter for shll/shrl/shra (immediate and register-amount forms).
- Consumes operands read from the register file: `src_val` comes from read port 1, `reg_amt` from read port 2.
- Produces the write-back strobe, address and data that drive the register file write port.
- Shifts one bit per clock, so a 32-bit barrel shifter is not needed in the datapath.

---
 rtl/iter_shift_pkg.sv | 19 +
 rtl/iter_shift_step.sv | 22 ++
 rtl/iter_shift_unit.sv | 91 +++++++++
 tb/tb_iter_shift_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/iter_shift_pkg.sv
// Shared encodings and default widths for the iterative one-bit-per-cycle shifter.
package iter_shift_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_REG_AW  = 5;
  localparam int DEFAULT_SHAMT_W = 5;

  localparam logic [1:0] OP_SHLL = 2'b00;
  localparam logic [1:0] OP_SHRL = 2'b01;
  localparam logic [1:0] OP_SHRA = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } state_t;

endpackage

// File: rtl/iter_shift_step.sv
// Combinational single-bit shift of a word; op selects left, logical right or arithmetic right.
module iter_shift_step
  import iter_shift_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = data;
    case (op)
      OP_SHLL: result = {data[DATA_W-2:0], 1'b0};
      OP_SHRL: result = {1'b0, data[DATA_W-1:1]};
      OP_SHRA: result = {data[DATA_W-1], data[DATA_W-1:1]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter feeding the register-file write port; shifts one bit per clock
// and presents the result for exactly one write-back cycle.
module iter_shift_unit
  import iter_shift_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int REG_AW  = DEFAULT_REG_AW,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  src_val,
  input  logic               amt_sel,
  input  logic [SHAMT_W-1:0] imm_amt,
  input  logic [DATA_W-1:0]  reg_amt,
  input  logic [REG_AW-1:0]  dest_addr,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [REG_AW-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  // Handshake: start is a request pulse honoured only in IDLE; there is no ready
  // signal, so the issuer must watch busy. The result is valid exactly while wr_en=1.

  state_t             state;
  logic [SHAMT_W-1:0] count;
  logic [DATA_W-1:0]  data_q;
  logic [1:0]         op_q;
  logic [REG_AW-1:0]  dest_q;
  logic [SHAMT_W-1:0] start_amt;
  logic [DATA_W-1:0]  step_out;

  // Only the low SHAMT_W bits of the register amount carry meaning.
  logic unused_reg_amt_hi;
  assign unused_reg_amt_hi = ^reg_amt[DATA_W-1:SHAMT_W];

  always_comb begin
    start_amt = amt_sel ? reg_amt[SHAMT_W-1:0] : imm_amt;
    if (op == OP_PASS) start_amt = '0;
  end

  iter_shift_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .data  (data_q),
    .op    (op_q),
    .result(step_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      data_q <= '0;
      op_q   <= OP_SHLL;
      dest_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_q <= src_val;
            op_q   <= op;
            dest_q <= dest_addr;
            count  <= start_amt;
            state  <= (start_amt == '0) ? WB : SHIFT;
          end
        end
        SHIFT: begin
          data_q <= step_out;
          count  <= count - 1'b1;
          if (count == SHAMT_W'(1)) state <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write port is driven straight from state and the latched registers, so it
  // holds steady for the whole WB cycle and keeps its last values in IDLE.
  assign busy    = (state != IDLE);
  assign wr_en   = (state == WB);
  assign done    = wr_en;
  assign wr_addr = dest_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: latency, shift results, ignored starts and reset abort.
module tb_iter_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_val;
  logic        amt_sel;
  logic [4:0]  imm_amt;
  logic [31:0] reg_amt;
  logic [4:0]  dest_addr;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  iter_shift_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_val  (src_val),
    .amt_sel  (amt_sel),
    .imm_amt  (imm_amt),
    .reg_amt  (reg_amt),
    .dest_addr(dest_addr),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy,  1'b0);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_done"},  done,  1'b0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_idle_outputs(tag);
      tick();
    end
  endtask

  // Issue one op; walk every cycle until write-back, checking busy/wr_en/done each
  // cycle, then the result and the return to IDLE. mid_k>0 pulses a stray start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] src,
                        input logic sel, input logic [4:0] imm, input logic [31:0] ramt,
                        input logic [4:0] dest, input int exp_amt,
                        input logic [31:0] exp_data, input int mid_k);
    start = 1'b1; op = o; src_val = src; amt_sel = sel;
    imm_amt = imm; reg_amt = ramt; dest_addr = dest;
    tick();
    start     = 1'b0;
    src_val   = $urandom;
    reg_amt   = $urandom;
    imm_amt   = 5'($urandom_range(0, 31));
    dest_addr = 5'($urandom_range(0, 31));
    op        = 2'($urandom_range(0, 3));
    amt_sel   = 1'($urandom_range(0, 1));
    for (int k = 1; k <= exp_amt + 1; k++) begin
      start = (k == mid_k);
      check({tag, "_busy"},  busy,  1'b1);
      check({tag, "_wr_en"}, wr_en, (k == exp_amt + 1));
      check({tag, "_done"},  done,  (k == exp_amt + 1));
      if (k == exp_amt + 1) begin
        check({tag, "_wr_addr"}, wr_addr, dest);
        check({tag, "_wr_data"}, wr_data, exp_data);
      end
      tick();
    end
    start = 1'b0;
    check_idle_outputs({tag, "_after"});
    check({tag, "_hold_data"}, wr_data, exp_data);
    check({tag, "_hold_addr"}, wr_addr, dest);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; src_val = '0; amt_sel = 1'b0;
    imm_amt = '0; reg_amt = '0; dest_addr = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_wr_addr", wr_addr, 5'd0);
    check("reset_wr_data", wr_data, 32'd0);
    rst = 1'b1;
    idle_cycles(2, "post_reset");

    // shifts with immediate and register amounts
    run_op("shll_imm4",   2'b00, 32'h0000_0001, 1'b0, 5'd4, 32'h0,         5'd5,  4, 32'h0000_0010, 0);
    run_op("shra_reg3",   2'b10, 32'h8000_0000, 1'b1, 5'd9, 32'hFFFF_FFE3, 5'd7,  3, 32'hF000_0000, 0);
    run_op("shrl_reg3",   2'b01, 32'h8000_0000, 1'b1, 5'd9, 32'hFFFF_FFE3, 5'd8,  3, 32'h1000_0000, 0);
    run_op("shra_pos2",   2'b10, 32'h4000_0000, 1'b0, 5'd2, 32'h0,         5'd12, 2, 32'h1000_0000, 0);
    run_op("shll_msb1",   2'b00, 32'h8000_0001, 1'b0, 5'd1, 32'h0,         5'd13, 1, 32'h0000_0002, 0);
    // zero-cycle forms
    run_op("shrl_amt0",   2'b01, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h5,         5'd9,  0, 32'hDEAD_BEEF, 0);
    run_op("pass_imm7",   2'b11, 32'h1234_5678, 1'b0, 5'd7, 32'h0,         5'd10, 0, 32'h1234_5678, 0);
    // max amount with stray start, then back-to-back op to address 0
    run_op("shrl_amt31",  2'b01, 32'h8000_0000, 1'b0, 5'd31, 32'h0,        5'd11, 31, 32'h0000_0001, 10);
    run_op("b2b_dest0",   2'b00, 32'h0000_0003, 1'b0, 5'd2, 32'h0,         5'd0,  2, 32'h0000_000C, 0);
    idle_cycles(3, "b2b_quiet");

    // reset in the middle of an operation discards it
    start = 1'b1; op = 2'b00; src_val = 32'h0000_00FF; amt_sel = 1'b0;
    imm_amt = 5'd10; dest_addr = 5'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_idle_outputs("abort");
    check("abort_wr_addr", wr_addr, 5'd0);
    check("abort_wr_data", wr_data, 32'd0);
    idle_cycles(14, "abort_quiet");
    run_op("after_abort", 2'b01, 32'hF000_000F, 1'b0, 5'd4, 32'h0,         5'd21, 4, 32'h0F00_0000, 0);

    // reset held with start high never launches an op
    rst = 1'b0; start = 1'b1; op = 2'b00; src_val = 32'h1; imm_amt = 5'd3; dest_addr = 5'd4;
    tick();
    idle_cycles(3, "rst_start");
    rst = 1'b1; start = 1'b0;
    idle_cycles(5, "release_quiet");
    run_op("final_op",    2'b10, 32'h8000_00F0, 1'b0, 5'd4, 32'h0,         5'd31, 4, 32'hF800_000F, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
